// File: rtl/vm_input_conditioner_if.sv
// Signal bundle between the raw user/sensor inputs, the conditioner and the
// downstream vending-machine FSM. master drives the raw inputs; slave is the conditioner.
interface vm_input_conditioner_if;
    logic       coin1_raw;
    logic       coin5_raw;
    logic       bev_btn_raw;
    logic       chg_btn_raw;
    logic [1:0] coin_in;
    logic       beverage_take;
    logic       change_take;
    logic       pending_any;
    logic       drop_flag;

    modport master (
        output coin1_raw, coin5_raw, bev_btn_raw, chg_btn_raw,
        input  coin_in, beverage_take, change_take, pending_any, drop_flag
    );

    modport slave (
        input  coin1_raw, coin5_raw, bev_btn_raw, chg_btn_raw,
        output coin_in, beverage_take, change_take, pending_any, drop_flag
    );
endinterface

// File: rtl/vm_input_conditioner.sv
// Synchronises and debounces four raw inputs, queues their rising edges and
// replays them one at a time as spaced single-cycle pulses for the vending FSM.
module vm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 2,
    parameter int PEND_MAX        = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    vm_input_conditioner_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_GAP} state_e;

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [1:0] PEND_TOP = 2'(PEND_MAX);

    // Channel order: [0] coin1, [1] coin5, [2] beverage, [3] change.
    logic [3:0]      raw;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      stable_q, stable_d, stable_last_q;
    logic [3:0][7:0] cnt_q, cnt_d;
    logic [3:0]      evt_q, evt_d;
    logic [1:0][1:0] coin_pend_q, coin_pend_d;
    logic [1:0]      btn_pend_q, btn_pend_d;
    logic [1:0]      dec_coin, clr_btn;
    state_e          state_q, state_d;
    logic [7:0]      gap_q, gap_d;
    logic [1:0]      coin_in_q, coin_in_d;
    logic            bev_q, bev_d, chg_q, chg_d;
    logic            drop_q, drop_d;

    assign raw = {bus.chg_btn_raw, bus.bev_btn_raw, bus.coin5_raw, bus.coin1_raw};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    assign evt_d = stable_q & ~stable_last_q;

    // Issue arbiter: fixed priority coin5 > coin1 > beverage > change.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        coin_in_d = 2'b00;
        bev_d     = 1'b0;
        chg_d     = 1'b0;
        dec_coin  = 2'b00;
        clr_btn   = 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                if (coin_pend_q[1] != 2'd0) begin
                    dec_coin[1] = 1'b1;
                    coin_in_d   = 2'b10;
                    state_d     = ST_FIRE;
                end else if (coin_pend_q[0] != 2'd0) begin
                    dec_coin[0] = 1'b1;
                    coin_in_d   = 2'b01;
                    state_d     = ST_FIRE;
                end else if (btn_pend_q[0]) begin
                    clr_btn[0] = 1'b1;
                    bev_d      = 1'b1;
                    state_d    = ST_FIRE;
                end else if (btn_pend_q[1]) begin
                    clr_btn[1] = 1'b1;
                    chg_d      = 1'b1;
                    state_d    = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A simultaneous increment and decrement cancel, so saturation cannot drop an event then.
    always_comb begin
        coin_pend_d = coin_pend_q;
        drop_d      = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (evt_q[c] && !dec_coin[c]) begin
                if (coin_pend_q[c] == PEND_TOP) drop_d = 1'b1;
                else                            coin_pend_d[c] = coin_pend_q[c] + 2'd1;
            end else if (!evt_q[c] && dec_coin[c]) begin
                coin_pend_d[c] = coin_pend_q[c] - 2'd1;
            end
        end
        btn_pend_d = evt_q[3:2] | (btn_pend_q & ~clr_btn);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_last_q <= '0;
            cnt_q         <= '0;
            evt_q         <= '0;
            coin_pend_q   <= '0;
            btn_pend_q    <= '0;
            state_q       <= ST_IDLE;
            gap_q         <= '0;
            coin_in_q     <= 2'b00;
            bev_q         <= 1'b0;
            chg_q         <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_last_q <= stable_q;
            cnt_q         <= cnt_d;
            evt_q         <= evt_d;
            coin_pend_q   <= coin_pend_d;
            btn_pend_q    <= btn_pend_d;
            state_q       <= state_d;
            gap_q         <= gap_d;
            coin_in_q     <= coin_in_d;
            bev_q         <= bev_d;
            chg_q         <= chg_d;
            drop_q        <= drop_d;
        end
    end

    assign bus.coin_in       = coin_in_q;
    assign bus.beverage_take = bev_q;
    assign bus.change_take   = chg_q;
    assign bus.drop_flag     = drop_q;
    assign bus.pending_any   = (|coin_pend_q) | (|btn_pend_q) | (state_q != ST_IDLE);
endmodule

// File: tb/tb_vm_input_conditioner.sv
// Scoreboard bench: stimulus pushes expected pulses (channel + time window) into
// per-DUT queues; negedge monitors pop and compare whenever an output pulse appears.
module tb_vm_input_conditioner;
    localparam int D_A = 16;
    localparam int G_A = 2;
    localparam int D_B = 1;
    localparam int G_B = 8;

    typedef struct {
        int ch;       // 0 coin1, 1 coin5, 2 beverage, 3 change
        int tmin;
        int tmax;
        int spacing;  // exact distance from previous pulse, -1 when unconstrained
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   drops_a = 0;
    int   drops_b = 0;
    int   last_pulse [2] = '{-1, -1};
    exp_t q_a [$];
    exp_t q_b [$];

    vm_input_conditioner_if bus_a ();
    vm_input_conditioner_if bus_b ();

    vm_input_conditioner #(.DEBOUNCE_CYCLES(D_A), .GAP_CYCLES(G_A), .PEND_MAX(3)) dut_a (
        .clk (clk), .rstn (rstn), .bus (bus_a.slave)
    );
    vm_input_conditioner #(.DEBOUNCE_CYCLES(D_B), .GAP_CYCLES(G_B), .PEND_MAX(3)) dut_b (
        .clk (clk), .rstn (rstn), .bus (bus_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic observe(input int dut, input logic [1:0] ci, input logic bt, input logic ct);
        int   nact;
        int   ch;
        int   gap;
        exp_t e;
        nact = int'(ci[0]) + int'(ci[1]) + int'(bt) + int'(ct);
        if (nact == 0) return;
        gap = (dut == 0) ? G_A : G_B;
        check($sformatf("dut%0d_one_hot", dut), nact, 1);
        if      (ci == 2'b01) ch = 0;
        else if (ci == 2'b10) ch = 1;
        else if (ci == 2'b11) ch = 9;
        else if (bt)          ch = 2;
        else                  ch = 3;
        if (last_pulse[dut] >= 0)
            check_range($sformatf("dut%0d_min_spacing", dut), cyc - last_pulse[dut], gap + 2, 1 << 30);
        if ((dut == 0 && q_a.size() == 0) || (dut == 1 && q_b.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d_unexpected_pulse: got channel %0d at cycle %0d, expected none", dut, ch, cyc);
        end else begin
            e = (dut == 0) ? q_a.pop_front() : q_b.pop_front();
            check($sformatf("dut%0d_channel", dut), ch, e.ch);
            check_range($sformatf("dut%0d_latency", dut), cyc, e.tmin, e.tmax);
            if (e.spacing > 0)
                check($sformatf("dut%0d_spacing", dut), cyc - last_pulse[dut], e.spacing);
        end
        last_pulse[dut] = cyc;
    endtask

    always @(negedge clk) begin
        observe(0, bus_a.coin_in, bus_a.beverage_take, bus_a.change_take);
        observe(1, bus_b.coin_in, bus_b.beverage_take, bus_b.change_take);
        if (bus_a.drop_flag) drops_a++;
        if (bus_b.drop_flag) drops_b++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [3:0] m);
        bus_a.coin1_raw   = m[0];
        bus_a.coin5_raw   = m[1];
        bus_a.bev_btn_raw = m[2];
        bus_a.chg_btn_raw = m[3];
    endtask

    task automatic set_b(input logic [3:0] m);
        bus_b.coin1_raw   = m[0];
        bus_b.coin5_raw   = m[1];
        bus_b.bev_btn_raw = m[2];
        bus_b.chg_btn_raw = m[3];
    endtask

    // Reference model: events whose raw inputs settle high on the same cycle
    // are replayed in priority order, GAP+2 cycles apart, first one D+5 (+/-1) later.
    task automatic push_set(input int dut, input logic [3:0] mask, input int k);
        int   prio [4] = '{1, 0, 2, 3};
        int   n = 0;
        int   d = (dut == 0) ? D_A : D_B;
        int   g = (dut == 0) ? G_A : G_B;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (mask[prio[i]]) begin
                e.ch      = prio[i];
                e.tmin    = k + d + 4 + n * (g + 2);
                e.tmax    = k + d + 6 + n * (g + 2);
                e.spacing = (n == 0) ? -1 : g + 2;
                if (dut == 0) q_a.push_back(e);
                else          q_b.push_back(e);
                n++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         found;
        logic [3:0] mask;
        exp_t       e;

        rstn = 1'b0;
        set_a(4'b0000);
        set_b(4'b0000);
        tick(3);
        check("reset_coin_in", int'(bus_a.coin_in), 0);
        check("reset_bev", int'(bus_a.beverage_take), 0);
        check("reset_chg", int'(bus_a.change_take), 0);
        check("reset_pending_any", int'(bus_a.pending_any), 0);
        check("reset_drop", int'(bus_a.drop_flag), 0);
        check("reset_b_pending_any", int'(bus_b.pending_any), 0);
        rstn = 1'b1;
        tick(5);

        // Clean coin1 press held 40 cycles; the fall must produce nothing.
        set_a(4'b0001);
        push_set(0, 4'b0001, cyc);
        tick(40);
        set_a(4'b0000);
        tick(60);

        // Beverage button bounces every 5 cycles for 30 cycles, then holds.
        for (int i = 0; i < 3; i++) begin
            set_a(4'b0100);
            tick(5);
            set_a(4'b0000);
            tick(5);
        end
        set_a(4'b0100);
        push_set(0, 4'b0100, cyc);
        tick(40);
        set_a(4'b0000);
        tick(60);

        // coin5 and change together: coin5 first, change exactly GAP+2 later.
        set_a(4'b1010);
        push_set(0, 4'b1010, cyc);
        tick(45);
        set_a(4'b0000);
        tick(60);

        // Random channel subsets with random short bounces on press and release.
        for (int r = 0; r < 10; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int b = $urandom_range(0, 3); b > 0; b--) begin
                set_a(mask);
                tick($urandom_range(1, 12));
                set_a(4'b0000);
                tick($urandom_range(1, 12));
            end
            set_a(mask);
            push_set(0, mask, cyc);
            tick($urandom_range(40, 60));
            for (int b = $urandom_range(0, 3); b > 0; b--) begin
                set_a(4'b0000);
                tick($urandom_range(1, 12));
                set_a(mask);
                tick($urandom_range(1, 12));
            end
            set_a(4'b0000);
            tick(60);
        end

        // Short debounce, long gap: six coin1 edges back to back saturate the counter.
        k = cyc;
        for (int j = 0; j < 4; j++) begin
            e.ch      = 0;
            e.tmin    = k + D_B + 4 + j * (G_B + 2);
            e.tmax    = k + D_B + 6 + j * (G_B + 2);
            e.spacing = (j == 0) ? -1 : G_B + 2;
            q_b.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            set_b(4'b0001);
            tick(1);
            set_b(4'b0000);
            tick(1);
        end
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (q_b.size() == 0) found = 1;
        end
        check("burst_all_pulses_seen", found, 1);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (!bus_b.pending_any) found = 1;
            else @(negedge clk);
        end
        check("burst_pending_any_falls", found, 1);
        check("burst_pending_any_fall_time", cyc - last_pulse[1], G_B + 1);
        check("burst_drops", drops_b, 2);
        tick(20);

        // Reset in the gap after coin5 while coin1 and beverage are still pending.
        set_a(4'b0111);
        k = cyc;
        e.ch = 1; e.tmin = k + D_A + 4; e.tmax = k + D_A + 6; e.spacing = -1;
        q_a.push_back(e);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (bus_a.coin_in != 2'b00) found = 1;
        end
        check("rst_coin5_seen", found, 1);
        tick(1);
        check("rst_pending_before", int'(bus_a.pending_any), 1);
        rstn = 1'b0;
        set_a(4'b0000);
        #1;
        check("rst_coin_in", int'(bus_a.coin_in), 0);
        check("rst_bev", int'(bus_a.beverage_take), 0);
        check("rst_chg", int'(bus_a.change_take), 0);
        check("rst_pending_any", int'(bus_a.pending_any), 0);
        tick(3);
        rstn = 1'b1;
        tick(80);
        check("rst_pending_after", int'(bus_a.pending_any), 0);

        // Change button already high when reset releases.
        rstn = 1'b0;
        set_a(4'b1000);
        tick(3);
        rstn = 1'b1;
        push_set(0, 4'b1000, cyc);
        tick(150);
        check("held_chg_pending_any", int'(bus_a.pending_any), 0);
        set_a(4'b0000);
        tick(60);

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        check("drops_a", drops_a, 0);
        check("drops_b_total", drops_b, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
